// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and its consumers (mappers, VGA connector).
// Only pix_en flows into the generator; everything else is a registered output.
interface vga_timing_gen_if;
  logic        pix_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_tick;
  logic [15:0] frame_count;

  modport master (
    input  pix_en,
    output DrawX, DrawY, blank, hs, vs, frame_tick, frame_count
  );

  modport slave (
    output pix_en,
    input  DrawX, DrawY, blank, hs, vs, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: DrawX/DrawY, blank, active-low hs/vs, frame_tick/frame_count.
// Define VGA_SYNC_DELAY_EN to delay hs/vs by SYNC_DELAY vga_clk cycles to match mapper latency.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 2
) (
  input logic        vga_clk,
  input logic        reset,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // 11-bit constants so porch/sync sums never overflow the comparison.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]  x_q, y_q;
  logic [9:0]  x_next, y_next;
  logic [10:0] xn_w, yn_w;
  logic        frame_wrap;
  logic        blank_q, hs_raw, vs_raw, tick_q;
  logic [15:0] count_q;

  always_comb begin
    x_next     = x_q;
    y_next     = y_q;
    frame_wrap = 1'b0;
    if (vga.pix_en) begin
      if ({1'b0, x_q} == H_LAST) begin
        x_next = '0;
        if ({1'b0, y_q} == V_LAST) begin
          y_next     = '0;
          frame_wrap = 1'b1;
        end else begin
          y_next = y_q + 10'd1;
        end
      end else begin
        x_next = x_q + 10'd1;
      end
    end
  end

  assign xn_w = {1'b0, x_next};
  assign yn_w = {1'b0, y_next};

  // Outputs are decoded from the next counter values so they land in the same cycle as DrawX/DrawY.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= 1'b1;
      hs_raw  <= 1'b1;
      vs_raw  <= 1'b1;
      tick_q  <= 1'b0;
      count_q <= '0;
    end else begin
      x_q     <= x_next;
      y_q     <= y_next;
      blank_q <= (xn_w < H_VIS) && (yn_w < V_VIS);
      hs_raw  <= !((xn_w >= HS_START) && (xn_w < HS_END));
      vs_raw  <= !((yn_w >= VS_START) && (yn_w < VS_END));
      tick_q  <= frame_wrap;
      count_q <= count_q + {15'd0, frame_wrap};
    end
  end

  assign vga.DrawX       = x_q;
  assign vga.DrawY       = y_q;
  assign vga.blank       = blank_q;
  assign vga.frame_tick  = tick_q;
  assign vga.frame_count = count_q;

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_sr, vs_sr;

  // Free-running on vga_clk (not pix_en) to match the mapper ROM + colour register pipeline.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hs_sr <= '1;
      vs_sr <= '1;
    end else begin
      hs_sr[0] <= hs_raw;
      vs_sr[0] <= vs_raw;
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
      end
    end
  end

  assign vga.hs = hs_sr[SYNC_DELAY-1];
  assign vga.vs = vs_sr[SYNC_DELAY-1];
`else
  assign vga.hs = hs_raw;
  assign vga.vs = vs_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster so several full frames fit in a short run.
// Reference model tracks a linear pixel index per frame and derives coordinates/syncs from it.
module tb_vga_timing_gen;

  localparam int HV = 64, HF = 6, HS = 10, HB = 8;
  localparam int VV = 20, VF = 3, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int SD = 2;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        tick;
    logic [15:0] count;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [39:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // model state
  int pos = 0;
  int frames = 0;
  bit hs_hist[$];
  bit vs_hist[$];

  vga_timing_gen_if vga ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_DELAY(SD)
  ) dut (
    .vga_clk(clk),
    .reset  (rst),
    .vga    (vga)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit pe);
    exp_t e;
    bit tick;
    int x, y;
    bit hs_now, vs_now;
    tick = 1'b0;
    if (r) begin
      pos = 0;
      frames = 0;
      hs_hist = {1'b1, 1'b1};
      vs_hist = {1'b1, 1'b1};
    end else if (pe) begin
      pos = (pos + 1) % FRAME;
      if (pos == 0) begin
        tick = 1'b1;
        frames = (frames + 1) % 65536;
      end
    end
    x = pos % HT;
    y = pos / HT;
    hs_now = !(x >= HV + HF && x < HV + HF + HS);
    vs_now = !(y >= VV + VF && y < VV + VF + VS);
    e.x = 10'(x);
    e.y = 10'(y);
    e.blank = (x < HV) && (y < VV);
    e.tick = tick;
    e.count = 16'(frames);
`ifdef VGA_SYNC_DELAY_EN
    if (r) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
    end else begin
      e.hs = hs_hist.pop_front();
      e.vs = vs_hist.pop_front();
      hs_hist.push_back(hs_now);
      vs_hist.push_back(vs_now);
    end
`else
    e.hs = hs_now;
    e.vs = vs_now;
`endif
    exp_q.push_back(e);
  endtask

  task automatic drive_cycle(input bit r, input bit pe);
    #1;
    rst = r;
    vga.pix_en = pe;
    @(posedge clk);
    model_step(r, pe);
  endtask

  task automatic check_field(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // monitor: one output set per clock, compared on the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check_field("DrawX", {6'd0, vga.DrawX}, {6'd0, e.x});
      check_field("DrawY", {6'd0, vga.DrawY}, {6'd0, e.y});
      check_field("blank", {15'd0, vga.blank}, {15'd0, e.blank});
      check_field("hs", {15'd0, vga.hs}, {15'd0, e.hs});
      check_field("vs", {15'd0, vga.vs}, {15'd0, e.vs});
      check_field("frame_tick", {15'd0, vga.frame_tick}, {15'd0, e.tick});
      check_field("frame_count", vga.frame_count, e.count);
    end
  end

  initial begin
    vga.pix_en = 1'b0;
    // reset from power-up, arbitrary pix_en
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'($urandom_range(0, 1)));
    // free run, several frames
    for (int i = 0; i < 2 * FRAME + 100; i++) drive_cycle(1'b0, 1'b1);
    // alternating pix_en
    for (int i = 0; i < 2 * FRAME + 50; i++) drive_cycle(1'b0, 1'(i % 2 == 0));
    // reset mid-frame at a chosen position, reached within a bounded number of cycles
    for (int i = 0; i < FRAME + 10 && pos != 12 * HT + 30; i++) drive_cycle(1'b0, 1'b1);
    drive_cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1);
    // repeat reset for three cycles mid-line
    for (int i = 0; i < 500; i++) drive_cycle(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'($urandom_range(0, 1)));
    // random enable with occasional resets
    for (int i = 0; i < 9000; i++)
      drive_cycle(1'($urandom_range(0, 2999) == 0), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 2 * FRAME; i++) drive_cycle(1'b0, 1'b1);
    #1;
    rst = 1'b0;
    vga.pix_en = 1'b0;
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
